// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default baud divisor
// and 8N1 frame constants. Also intended for the future buffered receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // 100 MHz system clock / 115200 baud
  localparam int DEFAULT_BAUD_DIV = 868;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Next shift-register value after the LSB has been put on the line
  function automatic logic [7:0] shift_lsb_out(input logic [7:0] b);
    return {1'b0, b[7:1]};
  endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock FIFO with registered occupancy count. Head word is presented
// combinationally on dout; a read with the FIFO empty, or a write with the
// FIFO full, is ignored. Full/empty are derived from the registered count.
module sync_byte_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);

  localparam logic [AW:0] DEPTH_LEVEL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              wr_fire;
  logic              rd_fire;

  assign full    = (count_q == DEPTH_LEVEL);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;

  // Next pointer and occupancy; simultaneous write and read keep the count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 transmitter. Bytes written by the CPU port decode are queued
// in a FIFO; the frame FSM pops the head whenever it is idle or finishing a
// stop bit, so queued bytes go out back-to-back with no idle gap. The baud
// counter restarts at every pop, keeping each frame phase-locked to its pop.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data_in,
  input  logic       write_tx_data,
  output logic       tx_buffer_full,
  output logic       tx_buffer_half_full,
  output logic       tx_busy,
  output logic       tx_overflow,
  output logic       rs232_tx
);

  localparam int                BAUD_W        = $clog2(BAUD_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST     = BAUD_W'(BAUD_DIV - 1);
  localparam logic [2:0]        LAST_DATA_BIT = 3'(DATA_BITS - 1);
  localparam logic [2:0]        LAST_STOP_BIT = 3'(STOP_BITS - 1);
  localparam logic [FIFO_AW:0]  HALF_LEVEL    = (FIFO_AW+1)'(FIFO_DEPTH / 2);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              ovf_q, ovf_d;

  logic [7:0]        fifo_dout;
  logic [FIFO_AW:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              baud_end;

  sync_byte_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH),
    .AW     (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .wr_en (write_tx_data),
    .din   (tx_data_in),
    .rd_en (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign baud_end            = (baud_cnt_q == BAUD_LAST);
  assign tx_buffer_full      = fifo_full;
  assign tx_buffer_half_full = (fifo_count >= HALF_LEVEL);
  assign tx_busy             = (state_q != ST_IDLE) || !fifo_empty;
  assign tx_overflow         = ovf_q;
  assign rs232_tx            = tx_q;

  // Frame sequencing: next state, baud/bit counters, shift data and line level
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
    // A write is dropped only against the registered full flag, so a pop on
    // the same edge does not rescue it.
    ovf_d      = write_tx_data && fifo_full;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shreg_d    = fifo_dout;
          tx_d       = 1'b0;
          baud_cnt_d = '0;
          state_d    = ST_START;
        end
      end

      ST_START: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          tx_d       = shreg_q[0];
          shreg_d    = shift_lsb_out(shreg_q);
          state_d    = ST_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == LAST_DATA_BIT) begin
            bit_cnt_d = '0;
            tx_d      = 1'b1;
            state_d   = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shreg_q[0];
            shreg_d   = shift_lsb_out(shreg_q);
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_cnt_q != LAST_STOP_BIT) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (!fifo_empty) begin
            // Back-to-back: the next start bit begins on this same edge
            fifo_pop  = 1'b1;
            shreg_d   = fifo_dout;
            bit_cnt_d = '0;
            tx_d      = 1'b0;
            state_d   = ST_START;
          end else begin
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers; reset forces the line high and aborts any frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      ovf_q      <= ovf_d;
    end
  end

  // Shift register is pure data, reloaded on every pop
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered (BAUD_DIV=4, FIFO_DEPTH=4). A time-based
// reference model tracks queued bytes and frame windows; a line monitor
// decodes frames and checks them against the expected byte/start queues.
module tb_uart_tx_buffered;

  localparam int BAUD  = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int FRAME = 10 * BAUD;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data_in = 8'h00;
  logic       write_tx_data = 1'b0;
  logic       tx_buffer_full;
  logic       tx_buffer_half_full;
  logic       tx_busy;
  logic       tx_overflow;
  logic       rs232_tx;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .BAUD_DIV   (BAUD),
    .FIFO_DEPTH (DEPTH),
    .FIFO_AW    (AW)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .tx_data_in          (tx_data_in),
    .write_tx_data       (write_tx_data),
    .tx_buffer_full      (tx_buffer_full),
    .tx_buffer_half_full (tx_buffer_half_full),
    .tx_busy             (tx_busy),
    .tx_overflow         (tx_overflow),
    .rs232_tx            (rs232_tx)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         cyc = 0;
  logic [7:0] m_fifo[$];
  bit         m_active = 1'b0;
  int         m_frame_end = 0;
  bit         m_ovf = 1'b0;
  logic [7:0] exp_bytes[1024];
  int         exp_wr = 0;
  int         st_arr[1024];
  int         st_wr = 0;

  initial begin
    int         prev;
    logic [7:0] popped;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_fifo.delete();
        m_active = 1'b0;
        m_ovf    = 1'b0;
      end else begin
        cyc++;
        prev  = m_fifo.size();
        m_ovf = write_tx_data && (prev == DEPTH);
        if (m_active && cyc == m_frame_end) m_active = 1'b0;
        if (!m_active && prev > 0) begin
          popped       = m_fifo.pop_front();
          m_active     = 1'b1;
          m_frame_end  = cyc + FRAME;
          st_arr[st_wr] = cyc;
          st_wr++;
        end
        if (write_tx_data && prev < DEPTH) begin
          m_fifo.push_back(tx_data_in);
          exp_bytes[exp_wr] = tx_data_in;
          exp_wr++;
        end
      end
    end
  end

  // ---------------- line monitor / scoreboard ----------------
  int         exp_rd = 0;
  int         st_rd = 0;
  bit         in_frame = 1'b0;
  int         k = 0;
  bit         frame_bad = 1'b0;
  logic [7:0] rx = 8'h00;

  initial begin
    int bi;
    forever begin
      @(negedge clk);
      if (!reset) begin
        in_frame = 1'b0;
        exp_rd   = exp_wr;
        st_rd    = st_wr;
      end else begin
        chk("full",     tx_buffer_full,      m_fifo.size() == DEPTH);
        chk("half",     tx_buffer_half_full, m_fifo.size() >= DEPTH / 2);
        chk("busy",     tx_busy,             m_active || m_fifo.size() > 0);
        chk("overflow", tx_overflow,         m_ovf);
        if (!in_frame && rs232_tx == 1'b0) begin
          in_frame  = 1'b1;
          k         = 0;
          frame_bad = 1'b0;
          rx        = 8'h00;
          if (st_rd < st_wr) begin
            chk("start_cycle", cyc, st_arr[st_rd]);
            st_rd++;
          end else begin
            chk("spurious_start", 1, 0);
          end
        end
        if (in_frame) begin
          if (k < BAUD) begin
            if (rs232_tx !== 1'b0) frame_bad = 1'b1;
          end else if (k < 9 * BAUD) begin
            bi = k / BAUD - 1;
            if (k % BAUD == 0) rx[bi] = rs232_tx;
            else if (rs232_tx !== rx[bi]) frame_bad = 1'b1;
          end else begin
            if (rs232_tx !== 1'b1) frame_bad = 1'b1;
          end
          k++;
          if (k == FRAME) begin
            in_frame = 1'b0;
            chk("frame_shape", frame_bad, 0);
            if (exp_rd < exp_wr) begin
              chk("byte", rx, exp_bytes[exp_rd]);
              exp_rd++;
            end else begin
              chk("byte_unexpected", 1, 0);
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic put(input logic [7:0] b);
    @(negedge clk);
    write_tx_data = 1'b1;
    tx_data_in    = b;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      write_tx_data = 1'b0;
      tx_data_in    = 8'($urandom);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    gap(1);
    while ((m_active || m_fifo.size() > 0 || in_frame) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    chk("drain_bound", budget < 2000, 1);
    chk("all_bytes_sent", exp_rd, exp_wr);
    gap(3);
  endtask

  task automatic wait_cyc(input int target);
    int budget;
    budget = 0;
    while (cyc != target && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    chk("wait_bound", budget < 500, 1);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    reset         = 1'b0;
    write_tx_data = 1'b0;
    #1;
    chk({tag, "_tx"},   rs232_tx,            1);
    chk({tag, "_full"}, tx_buffer_full,      0);
    chk({tag, "_half"}, tx_buffer_half_full, 0);
    chk({tag, "_busy"}, tx_busy,             0);
    chk({tag, "_ovf"},  tx_overflow,         0);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int s;
    repeat (3) @(negedge clk);
    chk("por_tx",   rs232_tx,            1);
    chk("por_full", tx_buffer_full,      0);
    chk("por_half", tx_buffer_half_full, 0);
    chk("por_busy", tx_busy,             0);
    chk("por_ovf",  tx_overflow,         0);
    #2;
    reset = 1'b1;
    gap(3);

    // reset asserted while a start bit is on the line
    put(8'h5A);
    gap(3);
    chk("t1_start_low", rs232_tx, 0);
    async_reset("t1_rst");
    gap(20);

    // single byte
    put(8'hA5);
    drain();

    // back-to-back
    put(8'h00);
    put(8'hFF);
    drain();

    // fill and overflow, then write-while-full on the STOP->START pop edge
    for (int b = 8'h10; b <= 8'h15; b++) put(8'(b));
    gap(1);
    chk("t4_overflow", tx_overflow,    1);
    chk("t4_full",     tx_buffer_full, 1);
    wait_cyc(m_frame_end - 2);
    put(8'h77);
    gap(1);
    chk("t5_overflow", tx_overflow,         1);
    chk("t5_full",     tx_buffer_full,      0);
    chk("t5_half",     tx_buffer_half_full, 1);
    drain();

    // reset during bit3 of 0x3C with two bytes queued
    put(8'h3C);
    put(8'hAA);
    put(8'h55);
    gap(1);
    s = m_frame_end - FRAME;
    wait_cyc(s + 16);
    async_reset("t6_rst");
    gap(60);
    chk("t6_no_frames", st_rd, st_wr);
    chk("t6_line_idle", rs232_tx, 1);
    put(8'h81);
    drain();

    // randomized traffic, including bursts that overflow
    for (int n = 0; n < 40; n++) begin
      put(8'($urandom));
      gap($urandom_range(0, 12));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
